counter_ram_sched: RTL

Round-robin scheduler that shares the single port of the counter RAM (ContadoresRAM, ADDR_W address / CNT_W count) between N_REQ event sources. Each source posts READ, INC or CLEAR requests. The block arbitrates them, drives the RAM strobes, and returns the pre-operation count and an overflow flag. After every reset it runs a clear sweep over all RAM entries, so counters start from a known zero without software help.

---
 rtl/counter_ram_pkg.sv | 24 ++
 rtl/counter_ram_sched_if.sv | 28 ++
 rtl/ContadoresRAM.sv | 31 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/counter_ram_sched.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/counter_ram_pkg.sv
// Shared types for the counter RAM scheduler: operation codes, FSM states and op-field width.
package counter_ram_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_READ  = 2'b00,
    OP_INC   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    ARB  = 2'b01,
    EXEC = 2'b10
  } state_t;

  // True for the ops that strobe a write into the counter RAM.
  function automatic logic op_writes(input op_t op);
    return (op == OP_INC) || (op == OP_CLEAR);
  endfunction

endpackage

// File: rtl/counter_ram_sched_if.sv
// Requester-side bundle of the scheduler: per-source request/op/address in, grant and results out.
interface counter_ram_sched_if
  import counter_ram_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 4,
  parameter int N_REQ  = 4
) ();

  logic [N_REQ-1:0]        req_i;
  logic [OP_W*N_REQ-1:0]   op_i;
  logic [ADDR_W*N_REQ-1:0] addr_i;
  logic [N_REQ-1:0]        ack_o;
  logic [CNT_W-1:0]        rdata_o;
  logic                    ovf_o;
  logic                    busy_o;

  modport master (
    output req_i, op_i, addr_i,
    input  ack_o, rdata_o, ovf_o, busy_o
  );

  modport slave (
    input  req_i, op_i, addr_i,
    output ack_o, rdata_o, ovf_o, busy_o
  );

endinterface

// File: rtl/ContadoresRAM.sv
// Counter RAM: synchronous increment/clear on write_enable, asynchronous read of the addressed count.
module ContadoresRAM #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] adress,
  input  logic              count_read,
  input  logic              count_reset,
  output logic [CNT_W-1:0]  count_out
);

  logic [CNT_W-1:0] mem_r [2**ADDR_W];

  // Clear wins over increment; counts wrap naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      if (count_reset) begin
        mem_r[adress] <= '0;
      end else if (count_read) begin
        mem_r[adress] <= mem_r[adress] + CNT_W'(1);
      end else begin
        mem_r[adress] <= mem_r[adress];
      end
    end
  end

  assign count_out = mem_r[adress];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] idx_s;

  // Scan from the farthest candidate back to ptr so the closest pending one is written last.
  always_comb begin
    winner = '0;
    grant  = '0;
    idx_s  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_s = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[idx_s]) begin
        winner = idx_s;
      end else begin
        winner = winner;
      end
    end
    if (|req) begin
      grant[winner] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/counter_ram_sched.sv
// Round-robin scheduler sharing one counter RAM port among N_REQ sources; clears the RAM after reset.
module counter_ram_sched
  import counter_ram_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 4,
  parameter int N_REQ  = 4
) (
  input  logic                clk,
  input  logic                gen_reset,
  counter_ram_sched_if.slave  bus,
  output logic                ram_write_enable,
  output logic [ADDR_W-1:0]   ram_adress,
  output logic                ram_count_read,
  output logic                ram_count_reset,
  input  logic [CNT_W-1:0]    ram_count_out
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] sweep_r;
  logic [IDX_W-1:0]  ptr_r;
  logic [IDX_W-1:0]  win_r;
  op_t               op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  rdata_r;
  logic              ovf_r;

  logic [N_REQ-1:0]  grant_s;
  logic [IDX_W-1:0]  win_s;
  op_t               sel_op_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [N_REQ-1:0]  ack_s;
  logic              busy_s;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req    (bus.req_i),
    .ptr    (ptr_r),
    .grant  (grant_s),
    .winner (win_s)
  );

  assign sel_op_s   = op_t'(bus.op_i[int'(win_s)*OP_W +: OP_W]);
  assign sel_addr_s = bus.addr_i[int'(win_s)*ADDR_W +: ADDR_W];

  // State register.
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      state_r <= INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: sweep until the last entry, then alternate ARB/EXEC per served request.
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT: begin
        if (sweep_r == {ADDR_W{1'b1}}) begin
          state_s = ARB;
        end else begin
          state_s = INIT;
        end
      end
      ARB: begin
        if (|grant_s) begin
          state_s = EXEC;
        end else begin
          state_s = ARB;
        end
      end
      EXEC:    state_s = ARB;
      default: state_s = INIT;
    endcase
  end

  // Datapath registers: sweep index, latched request, results and round-robin pointer.
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      sweep_r <= '0;
      ptr_r   <= '0;
      win_r   <= '0;
      op_r    <= OP_READ;
      addr_r  <= '0;
      rdata_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      ovf_r <= 1'b0;
      case (state_r)
        INIT: sweep_r <= sweep_r + ADDR_W'(1);
        ARB: begin
          if (|grant_s) begin
            win_r  <= win_s;
            op_r   <= sel_op_s;
            addr_r <= sel_addr_s;
          end
        end
        EXEC: begin
          // The RAM read is asynchronous, so this is the count before the update lands.
          rdata_r <= ram_count_out;
          ovf_r   <= (op_r == OP_INC) && (&ram_count_out);
          if (win_r == IDX_W'(N_REQ - 1)) begin
            ptr_r <= '0;
          end else begin
            ptr_r <= win_r + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the state register; the sweep strobes are gated while reset is held.
  always_comb begin
    ack_s            = '0;
    busy_s           = 1'b0;
    ram_write_enable = 1'b0;
    ram_count_read   = 1'b0;
    ram_count_reset  = 1'b0;
    ram_adress       = '0;
    case (state_r)
      INIT: begin
        busy_s     = 1'b1;
        ram_adress = sweep_r;
        if (!gen_reset) begin
          ram_write_enable = 1'b1;
          ram_count_reset  = 1'b1;
        end else begin
          ram_write_enable = 1'b0;
          ram_count_reset  = 1'b0;
        end
      end
      ARB: begin
        ram_adress = '0;
      end
      EXEC: begin
        ram_adress   = addr_r;
        ack_s[win_r] = 1'b1;
        ram_write_enable = op_writes(op_r);
        ram_count_read   = (op_r == OP_INC);
        ram_count_reset  = (op_r == OP_CLEAR);
      end
      default: begin
        ack_s = '0;
      end
    endcase
  end

  assign bus.ack_o   = ack_s;
  assign bus.busy_o  = busy_s;
  assign bus.rdata_o = rdata_r;
  assign bus.ovf_o   = ovf_r;

endmodule
